// File: rtl/if_stage_pkg.sv
// Shared pipeline-register types for the fetch stage: IF/ID payload,
// fetch-state encoding and the bubble instruction.
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [8:0]  Curr_Pc;
    logic [31:0] Curr_Instr;
  } if_id_reg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_REDIRECT
  } fetch_state_e;

endpackage

// File: rtl/if_pc_reg.sv
// 9-bit program counter: reset, load word-aligned target, hold, or advance by 4
// (wrapping modulo 512).
module if_pc_reg #(
  parameter logic [8:0] RESET_PC = 9'h000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_hold,
  input  logic       i_load,
  input  logic [8:0] i_target,
  output logic [8:0] o_pc
);

  logic [8:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= {i_target[8:2], 2'b00};
    end else if (!i_hold) begin
      r_pc <= r_pc + 9'd4;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word addresses to a synchronous-read memory
// and registers the returned word into the IF/ID payload, with stall and redirect.
module if_stage #(
  parameter logic [8:0]  RESET_PC  = 9'h000,
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [8:0]             branch_target,
  output logic [8:0]             imem_addr,
  input  logic [31:0]            imem_rdata,
  output if_stage_pkg::if_id_reg if_id,
  output logic                   if_id_valid
);

  import if_stage_pkg::*;

  logic [8:0]   w_pc;
  logic         w_hold;
  logic [8:0]   r_fetch_pc;
  fetch_state_e r_state;
  if_id_reg     r_if_id;
  logic         r_if_id_valid;

  assign w_hold = stall & ~branch_taken;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_hold   (w_hold),
    .i_load   (branch_taken),
    .i_target (branch_target),
    .o_pc     (w_pc)
  );

  // While held, re-issue the in-flight address so the word is present on release.
  assign imem_addr = (w_hold && !reset) ? r_fetch_pc : w_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_state       <= ST_BOOT;
      r_if_id       <= '{Curr_Pc: '0, Curr_Instr: NOP_INSTR};
      r_if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      r_fetch_pc    <= w_pc;
      r_state       <= ST_REDIRECT;
      r_if_id       <= '{Curr_Pc: '0, Curr_Instr: NOP_INSTR};
      r_if_id_valid <= 1'b0;
    end else if (!stall) begin
      r_fetch_pc <= w_pc;
      r_state    <= ST_RUN;
      if (r_state == ST_RUN) begin
        r_if_id       <= '{Curr_Pc: r_fetch_pc, Curr_Instr: imem_rdata};
        r_if_id_valid <= 1'b1;
      end else begin
        r_if_id       <= '{Curr_Pc: r_fetch_pc, Curr_Instr: NOP_INSTR};
        r_if_id_valid <= 1'b0;
      end
    end
  end

  assign if_id       = r_if_id;
  assign if_id_valid = r_if_id_valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then randomized traffic,
// checked against an instruction-stream model (next address + pending bubbles).
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [8:0]  P_RESET_PC = 9'h000;
  localparam logic [31:0] P_NOP      = 32'h0000_0013;

  logic       clk = 1'b0;
  logic       reset, stall, branch_taken;
  logic [8:0] branch_target, imem_addr;
  logic [31:0] imem_rdata;
  if_id_reg   if_id;
  logic       if_id_valid;

  logic [31:0] mem [128];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Model: next real instruction address and how many bubbles precede it.
  logic [8:0]  m_next;
  int          m_bub;
  int          m_bub_pc;
  logic [8:0]  m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  bit          m_pc_known;

  if_stage #(
    .RESET_PC  (P_RESET_PC),
    .NOP_INSTR (P_NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id         (if_id),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr[8:2]];

  task automatic step(input logic rst, input logic st, input logic br,
                      input logic [8:0] tgt, input string tag);
    reset = rst; stall = st; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    if (rst) begin
      m_pc = 9'h000; m_instr = P_NOP; m_valid = 1'b0; m_pc_known = 1'b1;
      m_bub = 1; m_bub_pc = int'(P_RESET_PC); m_next = P_RESET_PC;
    end else if (br) begin
      m_pc = 9'h000; m_instr = P_NOP; m_valid = 1'b0; m_pc_known = 1'b1;
      m_bub = 1; m_bub_pc = -1; m_next = {tgt[8:2], 2'b00};
    end else if (!st) begin
      if (m_bub > 0) begin
        m_valid = 1'b0; m_instr = P_NOP;
        m_pc_known = (m_bub_pc >= 0);
        m_pc = m_bub_pc[8:0];
        m_bub = m_bub - 1;
      end else begin
        m_valid = 1'b1; m_pc = m_next; m_pc_known = 1'b1;
        m_instr = mem[m_next[8:2]];
        m_next = 9'((int'(m_next) + 4) % 512);
      end
    end
    #1;
    n_total++;
    assert (if_id_valid === m_valid) n_pass++;
    else $error("FAIL %s valid: got %b want %b", tag, if_id_valid, m_valid);
    n_total++;
    assert (if_id.Curr_Instr === m_instr) n_pass++;
    else $error("FAIL %s instr: got %h want %h", tag, if_id.Curr_Instr, m_instr);
    if (m_pc_known) begin
      n_total++;
      assert (if_id.Curr_Pc === m_pc) n_pass++;
      else $error("FAIL %s pc: got %h want %h", tag, if_id.Curr_Pc, m_pc);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    m_next = P_RESET_PC; m_bub = 1; m_bub_pc = 0; m_pc = '0; m_instr = P_NOP;
    m_valid = 1'b0; m_pc_known = 1'b1;
    for (int unsigned i = 0; i < 128; i++) mem[i] = 32'(i * 4);

    // Reset state; reset must win over stall/branch and drive imem_addr from pc.
    step(1'b1, 1'b0, 1'b0, 9'h000, "reset0");
    reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 9'h0A4;
    #1;
    n_total++;
    assert (imem_addr === P_RESET_PC) n_pass++;
    else $error("FAIL reset_addr: got %h want %h", imem_addr, P_RESET_PC);
    step(1'b1, 1'b1, 1'b1, 9'h0A4, "reset1");

    // Boot: one bubble, then 0x000, 0x004, 0x008, 0x00C.
    step(1'b0, 1'b0, 1'b0, 9'h000, "boot_bubble");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 9'h000, "boot_run");

    // Stall with 0x010 in flight: 0x00C holds, then 0x010, 0x014.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 9'h000, "stall_hold");
      n_total++;
      assert (imem_addr === 9'h010) n_pass++;
      else $error("FAIL stall_replay_addr: got %h want %h", imem_addr, 9'h010);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 9'h000, "stall_release");

    // Redirect to 0x083 while running: two bubbles then 0x080.
    step(1'b0, 1'b0, 1'b1, 9'h083, "br_edge");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 9'h000, "br_follow");

    // Branch plus stall together, landing near the wrap point.
    step(1'b0, 1'b1, 1'b1, 9'h1F8, "brstall_edge");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 9'h000, "wrap_run");

    // Reset during a stall at 0x040.
    step(1'b0, 1'b0, 1'b1, 9'h040, "to40");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 9'h000, "to40_run");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 9'h000, "stall40");
    step(1'b1, 1'b1, 1'b0, 9'h000, "rst_in_stall");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 9'h000, "restart");

    // Reset during a redirect, and a branch taken while still in BOOT.
    step(1'b0, 1'b0, 1'b1, 9'h100, "br_then_rst");
    step(1'b1, 1'b0, 1'b0, 9'h000, "rst_in_redirect");
    step(1'b0, 1'b0, 1'b1, 9'h0C6, "br_in_boot");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 9'h000, "boot_br_run");

    // Randomized traffic over fresh memory contents.
    reset = 1'b1;
    for (int unsigned i = 0; i < 128; i++) mem[i] = $urandom;
    step(1'b1, 1'b0, 1'b0, 9'h000, "rand_reset");
    for (int i = 0; i < 500; i++) begin
      logic rr, rs, rb;
      logic [8:0] rt;
      rr = ($urandom_range(99) < 2);
      rs = ($urandom_range(3) == 0);
      rb = ($urandom_range(7) == 0);
      rt = 9'($urandom);
      step(rr, rs, rb, rt, "random");
      n_total++;
      assert (imem_addr[1:0] === 2'b00) n_pass++;
      else $error("FAIL addr_align: got %h want %h", imem_addr[1:0], 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 9'h000, byte address of the first fetch after reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, bubble instruction (addi x0,x0,0).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hazard hold from decode; freeze PC and IF/ID output.
REQ-006 branch_taken  in  1  redirect request from execute, one-cycle pulse.
REQ-007 branch_target  in  9  redirect byte address; bits [1:0] ignored, treated as 00.
REQ-008 imem_addr  out  9  instruction memory byte address, word aligned.
REQ-009 imem_rdata  in  32  synchronous-read data for the address sampled on the previous edge.
REQ-010 if_id  out  if_id_reg  registered IF/ID payload {Curr_Pc[8:0], Curr_Instr[31:0]}.
REQ-011 if_id_valid  out  1  if_id holds a real instruction, not a bubble.

Function
REQ-012 The block SHALL keep pc_q (next address to issue) and fetch_pc_q (address whose data arrives this cycle).
REQ-013 The state machine SHALL have three states.
- BOOT: entered on reset; no valid fetch in flight.
- RUN: fetch in flight is valid.
- REDIRECT: fetch in flight was issued before a taken branch and is discarded.
REQ-014 Transitions: BOOT->RUN and REDIRECT->RUN unconditionally; any state->REDIRECT when branch_taken=1; RUN->RUN otherwise.
REQ-015 imem_addr SHALL equal fetch_pc_q when stall=1 and branch_taken=0, else pc_q (combinational replay mux).
REQ-016 With no stall or branch, each edge: fetch_pc_q<=pc_q, pc_q<=pc_q+4 modulo 512, and if_id<={fetch_pc_q, imem_rdata} with if_id_valid<=(state==RUN).
REQ-017 In BOOT or REDIRECT, if_id SHALL load {fetch_pc_q, NOP_INSTR} with if_id_valid=0.
REQ-018 stall=1 and branch_taken=0: pc_q, fetch_pc_q, state, if_id and if_id_valid SHALL hold; the replay mux re-reads fetch_pc_q so imem_rdata is correct in the release cycle.
REQ-019 branch_taken=1 SHALL override stall: pc_q<={branch_target[8:2],2'b00}; state<=REDIRECT; if_id<={0, NOP_INSTR}; if_id_valid<=0.
REQ-020 Redirect latency: the target instruction SHALL appear on if_id two edges after the edge sampling branch_taken, with exactly two bubbles.
REQ-021 Steady-state throughput SHALL be one instruction per cycle; address issue to if_id latency is two edges.
REQ-022 PC arithmetic SHALL be 9-bit unsigned; 9'h1FC+4 wraps to 9'h000 with no flag.
REQ-023 A branch_taken in BOOT SHALL redirect normally; the boot fetch is discarded.

Reset
REQ-024 reset=1 SHALL override stall and branch_taken on the same edge.
REQ-025 On reset: pc_q=RESET_PC, fetch_pc_q=RESET_PC, state=BOOT, if_id={9'h000, NOP_INSTR}, if_id_valid=0.
REQ-026 imem_addr during reset SHALL equal pc_q; after reset release, first valid if_id carries RESET_PC on the second edge.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state with no residual valid output.

Structure
REQ-028 if_id_reg SHALL remain in the shared pipeline-register package; the fetch-state enum (BOOT/RUN/REDIRECT) and NOP_INSTR constant SHALL be added there.
REQ-029 PC update logic SHALL be one sub-module, if_pc_reg (9-bit register with hold, load-target and +4).

Verification
REQ-030 Reset release, memory word = address: if_id_valid=0 for 1 edge, then Curr_Pc 0x000, 0x004, 0x008, valid=1 on consecutive edges.
REQ-031 stall=1 for 3 cycles while fetching 0x010: if_id holds 0x00C; after release 0x010, 0x014 follow, none skipped or duplicated.
REQ-032 branch_taken=1, target 0x083, while RUN at 0x020: two bubbles (NOP, valid=0), then Curr_Pc=0x080.
REQ-033 branch_taken=1 and stall=1 in the same cycle: redirect wins; target appears two edges later.
REQ-034 Free-run from 0x1F8: Curr_Pc sequence 0x1F8, 0x1FC, 0x000, 0x004.
REQ-035 reset asserted during a stall at 0x040: next edge if_id={0, 0x00000013}, valid=0; restart from RESET_PC.
